// File: rtl/drac_pkg.sv
// Shared types and constants for the dcache request arbiter slice.
package drac_pkg;

  localparam int DCACHE_NUM_REQ   = 3;
  localparam int DCACHE_TID_W     = 7;
  localparam int DCACHE_SID_W     = 2;
  localparam int DCACHE_MAX_OUTST = 8;

  typedef enum logic [3:0] {
    HPDCACHE_REQ_LOAD     = 4'h0,
    HPDCACHE_REQ_STORE    = 4'h1,
    HPDCACHE_REQ_AMO_SWAP = 4'h2,
    HPDCACHE_REQ_AMO_ADD  = 4'h3,
    HPDCACHE_REQ_AMO_AND  = 4'h4,
    HPDCACHE_REQ_AMO_OR   = 4'h5,
    HPDCACHE_REQ_AMO_XOR  = 4'h6,
    HPDCACHE_REQ_AMO_MAX  = 4'h7,
    HPDCACHE_REQ_AMO_MIN  = 4'h8
  } hpdcache_req_op_t;

  typedef struct packed {
    logic [31:0]             addr;
    logic [31:0]             wdata;
    hpdcache_req_op_t        op;
    logic [DCACHE_TID_W-1:0] tid;
    logic [DCACHE_SID_W-1:0] sid;
  } hpdcache_req_t;

  typedef struct packed {
    logic [31:0]             rdata;
    logic                    error;
    logic [DCACHE_TID_W-1:0] tid;
    logic [DCACHE_SID_W-1:0] sid;
  } hpdcache_rsp_t;

  typedef enum logic [1:0] {ARB, HOLD, DRAIN, AMO_WAIT} arb_state_t;

  function automatic logic is_amo(input hpdcache_req_op_t op);
    return op inside {HPDCACHE_REQ_AMO_SWAP, HPDCACHE_REQ_AMO_ADD, HPDCACHE_REQ_AMO_AND,
                      HPDCACHE_REQ_AMO_OR, HPDCACHE_REQ_AMO_XOR, HPDCACHE_REQ_AMO_MAX,
                      HPDCACHE_REQ_AMO_MIN};
  endfunction

endpackage

// File: rtl/dcache_txn_tracker.sv
// Per-requester transaction tracker: one pending bit per tid plus an
// outstanding-request counter. A set and clear on the same bit keeps it set.
module dcache_txn_tracker
  import drac_pkg::*;
#(
  parameter int TID_W     = DCACHE_TID_W,
  parameter int MAX_OUTST = DCACHE_MAX_OUTST
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             i_set,
  input  logic [TID_W-1:0] i_set_tid,
  input  logic             i_clr,
  input  logic [TID_W-1:0] i_clr_tid,
  input  logic [TID_W-1:0] i_qry_tid,
  output logic             o_eligible,
  output logic             o_clr_hit,
  output logic             o_empty
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int NTID  = 2 ** TID_W;

  logic [NTID-1:0]  r_pending;
  logic [CNT_W-1:0] r_outst;
  logic [NTID-1:0]  w_set_mask;
  logic [NTID-1:0]  w_clr_mask;

  // Decode set/clear requests into one-hot bit masks.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    w_set_mask[i_set_tid] = i_set;
    w_clr_mask[i_clr_tid] = i_clr;
  end

  // Pending table and counter; a same-cycle set and clear nets to no count change.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pending <= '0;
      r_outst   <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      case ({i_set, i_clr})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   r_outst <= r_outst - CNT_W'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  assign o_eligible = !r_pending[i_qry_tid] && (r_outst < CNT_W'(MAX_OUTST));
  assign o_clr_hit  = r_pending[i_clr_tid];
  assign o_empty    = (r_outst == '0);

endmodule

// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one HPDC request port between requesters,
// with AMO serialisation and sid-based response routing.
//
// state    | meaning
// ARB      | pick first eligible requester from rr_ptr, issue same cycle
// HOLD     | latched grantee presented until the cache accepts it
// DRAIN    | AMO latched, waiting for all outstanding requests to retire
// AMO_WAIT | AMO sent, no grants until its response returns
module dcache_req_arbiter
  import drac_pkg::*;
#(
  parameter int NUM_REQ   = DCACHE_NUM_REQ,
  parameter int TID_W     = DCACHE_TID_W,
  parameter int MAX_OUTST = DCACHE_MAX_OUTST
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  hpdcache_req_t      req_i [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic               core_req_valid_o,
  output hpdcache_req_t      req_dcache_o,
  input  logic               dcache_ready_i,
  input  logic               dcache_valid_i,
  input  hpdcache_rsp_t      rsp_dcache_i,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  output hpdcache_rsp_t      rsp_o,
  output logic               sid_err_o,
  output logic               busy_o
);

  localparam int SID_W = DCACHE_SID_W;

  arb_state_t              r_state, w_next_state;
  logic [SID_W-1:0]        r_grant, w_gnt, w_pick, r_rr_ptr, r_amo_sid;
  logic [DCACHE_TID_W-1:0] r_amo_tid;
  logic                    r_sid_err;
  logic                    w_found, w_issue, w_send, w_total_zero, w_rsp_ok;
  logic [NUM_REQ-1:0]      w_trk_elig, w_trk_hit, w_trk_empty, w_clr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_trk
    dcache_txn_tracker #(.TID_W(TID_W), .MAX_OUTST(MAX_OUTST)) u_trk (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .i_set      (req_ready_o[gi]),
      .i_set_tid  (req_i[gi].tid),
      .i_clr      (w_clr[gi]),
      .i_clr_tid  (rsp_dcache_i.tid),
      .i_qry_tid  (req_i[gi].tid),
      .o_eligible (w_trk_elig[gi]),
      .o_clr_hit  (w_trk_hit[gi]),
      .o_empty    (w_trk_empty[gi])
    );
  end

  assign w_total_zero = &w_trk_empty;
  assign busy_o       = !w_total_zero || (r_state != ARB);
  assign sid_err_o    = r_sid_err;
  assign rsp_o        = rsp_dcache_i;
  assign rsp_valid_o  = w_clr;
  assign w_rsp_ok     = |w_clr;

  // Route a response only when its sid is in range and its tid is pending.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_clr[i] = dcache_valid_i && (rsp_dcache_i.sid == SID_W'(i)) && w_trk_hit[i];
  end

  // Round-robin scan starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid_i[idx] && w_trk_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = SID_W'(idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ARB;
    else         r_state <= w_next_state;
  end

  // Next state, grantee selection and issue decision.
  always_comb begin
    w_next_state = r_state;
    w_gnt        = r_grant;
    w_issue      = 1'b0;
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_gnt = w_pick;
          if (is_amo(req_i[w_pick].op) && !w_total_zero) begin
            w_next_state = DRAIN;
          end else begin
            w_issue = 1'b1;
            if (dcache_ready_i) w_next_state = is_amo(req_i[w_pick].op) ? AMO_WAIT : ARB;
            else                w_next_state = HOLD;
          end
        end
      end
      HOLD: begin
        w_issue = 1'b1;
        if (dcache_ready_i) w_next_state = is_amo(req_i[r_grant].op) ? AMO_WAIT : ARB;
      end
      DRAIN: begin
        if (w_total_zero) begin
          w_issue      = 1'b1;
          w_next_state = dcache_ready_i ? AMO_WAIT : HOLD;
        end
      end
      AMO_WAIT: begin
        if (w_rsp_ok && (rsp_dcache_i.sid == r_amo_sid) && (rsp_dcache_i.tid == r_amo_tid))
          w_next_state = ARB;
      end
      default: w_next_state = ARB;
    endcase
  end

  assign w_send = w_issue && dcache_ready_i;

  // Drive the HPDC request from the grantee, with sid replaced by its index.
  always_comb begin
    core_req_valid_o = w_issue;
    req_dcache_o     = '0;
    req_ready_o      = '0;
    if (w_issue) begin
      req_dcache_o     = req_i[w_gnt];
      req_dcache_o.sid = w_gnt;
    end
    for (int i = 0; i < NUM_REQ; i++)
      req_ready_o[i] = w_send && (w_gnt == SID_W'(i));
  end

  // Grant latch, rr pointer, AMO identity and sticky sid error.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_amo_sid <= '0;
      r_amo_tid <= '0;
      r_sid_err <= 1'b0;
    end else begin
      r_grant <= w_gnt;
      if (w_send) begin
        r_rr_ptr  <= (w_gnt == SID_W'(NUM_REQ - 1)) ? '0 : w_gnt + SID_W'(1);
        r_amo_sid <= w_gnt;
        r_amo_tid <= req_i[w_gnt].tid;
      end
      if (dcache_valid_i && !w_rsp_ok) r_sid_err <= 1'b1;
    end
  end

  // A requester whose request is being held must not withdraw it.
  a_hold_valid: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (r_state inside {HOLD, DRAIN}) |-> req_valid_i[r_grant]);

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench with a cycle-level behavioural model of the arbiter.
module tb_dcache_req_arbiter;
  import drac_pkg::*;

  localparam int NR = 3;
  localparam int M_FREE = 0, M_LOCK = 1, M_DRAIN = 2, M_WAIT = 3;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [NR-1:0] req_valid_i;
  hpdcache_req_t req_i [NR];
  logic [NR-1:0] req_ready_o;
  logic          core_req_valid_o;
  hpdcache_req_t req_dcache_o;
  logic          dcache_ready_i;
  logic          dcache_valid_i;
  hpdcache_rsp_t rsp_dcache_i;
  logic [NR-1:0] rsp_valid_o;
  hpdcache_rsp_t rsp_o;
  logic          sid_err_o;
  logic          busy_o;

  dcache_req_arbiter dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_i(req_i),
    .req_ready_o(req_ready_o), .core_req_valid_o(core_req_valid_o),
    .req_dcache_o(req_dcache_o), .dcache_ready_i(dcache_ready_i),
    .dcache_valid_i(dcache_valid_i), .rsp_dcache_i(rsp_dcache_i),
    .rsp_valid_o(rsp_valid_o), .rsp_o(rsp_o), .sid_err_o(sid_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int grant_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Model state: what each requester has in flight and what the arbiter is doing.
  bit m_pend [NR][128];
  int m_cnt [NR];
  int m_mode, m_lock, m_ptr, m_amo_sid, m_amo_tid;
  bit m_err;

  function automatic bit op_amo(input hpdcache_req_op_t op);
    return (op != HPDCACHE_REQ_LOAD) && (op != HPDCACHE_REQ_STORE);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_cnt[r] = 0;
      for (int t = 0; t < 128; t++) m_pend[r][t] = 1'b0;
    end
    m_mode = M_FREE; m_lock = 0; m_ptr = 0; m_amo_sid = 0; m_amo_tid = 0; m_err = 1'b0;
  endtask

  // Compare process: evaluate the model on the current inputs, check, advance.
  always @(negedge clk_i) begin
    int total, g, nmode, exp_rsp, rs, rt;
    bit ev, send, found, rok;
    hpdcache_req_t exp_req;
    if (!rstn_i) begin
      model_reset();
    end else begin
      total = m_cnt[0] + m_cnt[1] + m_cnt[2];
      ev = 1'b0; send = 1'b0; found = 1'b0; g = m_lock; nmode = m_mode;
      case (m_mode)
        M_FREE: begin
          for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (!found && req_valid_i[i] && !m_pend[i][req_i[i].tid] && m_cnt[i] < 8) begin
              found = 1'b1; g = i;
            end
          end
          if (found) begin
            if (op_amo(req_i[g].op) && total != 0) nmode = M_DRAIN;
            else ev = 1'b1;
          end
        end
        M_LOCK:  ev = 1'b1;
        M_DRAIN: ev = (total == 0);
        default: ;
      endcase
      if (ev) begin
        send = dcache_ready_i;
        if (send) nmode = op_amo(req_i[g].op) ? M_WAIT : M_FREE;
        else      nmode = M_LOCK;
      end
      rs = int'(rsp_dcache_i.sid);
      rt = int'(rsp_dcache_i.tid);
      rok = dcache_valid_i && (rs < NR) && m_pend[rs % NR][rt];
      exp_rsp = rok ? (1 << rs) : 0;
      if (m_mode == M_WAIT && rok && rs == m_amo_sid && rt == m_amo_tid) nmode = M_FREE;

      chk("core_req_valid", core_req_valid_o, ev);
      if (ev) begin
        exp_req = req_i[g];
        exp_req.sid = 2'(g);
        chk("req_payload", req_dcache_o === exp_req, 1);
      end
      chk("req_ready", req_ready_o, send ? (1 << g) : 0);
      chk("rsp_valid", rsp_valid_o, exp_rsp);
      if (dcache_valid_i) chk("rsp_data", rsp_o, rsp_dcache_i);
      chk("sid_err", sid_err_o, m_err);
      chk("busy", busy_o, (total != 0) || (m_mode != M_FREE));
      if (core_req_valid_o && dcache_ready_i) grant_log.push_back(int'(req_dcache_o.sid));

      if (rok) begin
        m_pend[rs][rt] = 1'b0;
        m_cnt[rs]--;
      end
      if (dcache_valid_i && !rok) m_err = 1'b1;
      if (send) begin
        m_pend[g][req_i[g].tid] = 1'b1;
        m_cnt[g]++;
        m_ptr = (g + 1) % NR;
        m_amo_sid = g;
        m_amo_tid = int'(req_i[g].tid);
      end
      if (nmode == M_LOCK || nmode == M_DRAIN) m_lock = g;
      m_mode = nmode;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input hpdcache_req_op_t op, input int tid);
    req_valid_i[r] = v;
    req_i[r].op    = op;
    req_i[r].tid   = 7'(tid);
    req_i[r].addr  = 32'(32'h1000 * (r + 1) + tid * 4);
    req_i[r].wdata = 32'(tid + 100 * r);
    req_i[r].sid   = 2'd3;
  endtask

  task automatic rsp(input logic v, input int sid, input int tid);
    dcache_valid_i     = v;
    rsp_dcache_i.sid   = 2'(sid);
    rsp_dcache_i.tid   = 7'(tid);
    rsp_dcache_i.rdata = 32'(32'hD000 + sid * 256 + tid);
    rsp_dcache_i.error = 1'b0;
  endtask

  task automatic do_reset();
    req_valid_i    = '0;
    for (int r = 0; r < NR; r++) req_i[r] = '0;
    dcache_ready_i = 1'b0;
    dcache_valid_i = 1'b0;
    rsp_dcache_i   = '0;
    rstn_i         = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
  endtask

  initial begin
    int exp2 [6];
    exp2 = '{0, 1, 2, 0, 1, 2};

    do_reset();
    #1;
    chk("rst_core_valid", core_req_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_sid_err", sid_err_o, 0);
    chk("rst_busy", busy_o, 0);

    // Two loads with the same tid from different requesters.
    set_req(0, 1, HPDCACHE_REQ_LOAD, 5); set_req(1, 1, HPDCACHE_REQ_LOAD, 5);
    dcache_ready_i = 1'b1; #1;
    chk("t1_c0_sid", req_dcache_o.sid, 0);
    chk("t1_c0_ready", req_ready_o, 3'b001);
    tick(); set_req(0, 0, HPDCACHE_REQ_LOAD, 5); #1;
    chk("t1_c1_sid", req_dcache_o.sid, 1);
    chk("t1_c1_ready", req_ready_o, 3'b010);
    tick(); set_req(1, 0, HPDCACHE_REQ_LOAD, 5); rsp(1, 1, 5); #1;
    chk("t1_rsp_r1", rsp_valid_o, 3'b010);
    tick(); rsp(1, 0, 5); #1;
    chk("t1_rsp_r0", rsp_valid_o, 3'b001);
    tick(); rsp(0, 0, 0); #1;
    chk("t1_idle_busy", busy_o, 0);
    chk("t1_no_err", sid_err_o, 0);

    // All three requesters valid continuously.
    do_reset(); grant_log.delete(); dcache_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1, HPDCACHE_REQ_LOAD, 10 + k);
      set_req(1, 1, HPDCACHE_REQ_LOAD, 20 + k);
      set_req(2, 1, HPDCACHE_REQ_LOAD, 30 + k);
      tick();
    end
    req_valid_i = '0; #1;
    chk("t2_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("t2_grant_order", grant_log[i], exp2[i]);

    // Stall while R1 is held; R0 and R2 appear during the stall.
    do_reset();
    set_req(1, 1, HPDCACHE_REQ_LOAD, 3); #1;
    chk("t3_c0_valid", core_req_valid_o, 1);
    chk("t3_c0_sid", req_dcache_o.sid, 1);
    tick();
    for (int k = 1; k < 4; k++) begin
      set_req(0, 1, HPDCACHE_REQ_LOAD, 1); set_req(2, 1, HPDCACHE_REQ_LOAD, 2); #1;
      chk("t3_hold_sid", req_dcache_o.sid, 1);
      chk("t3_hold_tid", req_dcache_o.tid, 3);
      chk("t3_hold_ready", req_ready_o, 0);
      tick();
    end
    dcache_ready_i = 1'b1; #1;
    chk("t3_c4_sid", req_dcache_o.sid, 1);
    chk("t3_c4_ready", req_ready_o, 3'b010);
    tick(); set_req(1, 0, HPDCACHE_REQ_LOAD, 3); #1;
    chk("t3_next_sid", req_dcache_o.sid, 2);
    chk("t3_next_ready", req_ready_o, 3'b100);
    tick();

    // AMO drains outstanding loads, then blocks grants until its response.
    do_reset(); dcache_ready_i = 1'b1;
    set_req(0, 1, HPDCACHE_REQ_LOAD, 1); tick();
    set_req(0, 1, HPDCACHE_REQ_LOAD, 2); tick();
    set_req(0, 0, HPDCACHE_REQ_LOAD, 2); set_req(2, 1, HPDCACHE_REQ_AMO_ADD, 7); #1;
    chk("t4_drain_c2", core_req_valid_o, 0);
    tick(); set_req(0, 1, HPDCACHE_REQ_LOAD, 3); rsp(1, 0, 1); #1;
    chk("t4_drain_c3", core_req_valid_o, 0);
    chk("t4_drain_busy", busy_o, 1);
    tick(); rsp(1, 0, 2); #1;
    chk("t4_drain_c4", core_req_valid_o, 0);
    tick(); rsp(0, 0, 0); #1;
    chk("t4_amo_valid", core_req_valid_o, 1);
    chk("t4_amo_sid", req_dcache_o.sid, 2);
    chk("t4_amo_op", req_dcache_o.op, HPDCACHE_REQ_AMO_ADD);
    chk("t4_amo_ready", req_ready_o, 3'b100);
    tick(); set_req(2, 0, HPDCACHE_REQ_AMO_ADD, 7); #1;
    chk("t4_wait_c6", core_req_valid_o, 0);
    tick(); rsp(1, 2, 7); #1;
    chk("t4_wait_c7", core_req_valid_o, 0);
    chk("t4_amo_rsp", rsp_valid_o, 3'b100);
    tick(); rsp(0, 0, 0); #1;
    chk("t4_arb_valid", core_req_valid_o, 1);
    chk("t4_arb_sid", req_dcache_o.sid, 0);
    chk("t4_arb_tid", req_dcache_o.tid, 3);
    tick(); req_valid_i = '0;

    // Outstanding limit: ninth load waits for a response.
    do_reset(); dcache_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1, HPDCACHE_REQ_LOAD, k);
      tick();
    end
    set_req(0, 1, HPDCACHE_REQ_LOAD, 8); rsp(1, 0, 0); #1;
    chk("t5_ninth_blocked", core_req_valid_o, 0);
    tick(); rsp(0, 0, 0); #1;
    chk("t5_ninth_valid", core_req_valid_o, 1);
    chk("t5_ninth_ready", req_ready_o, 3'b001);
    chk("t5_ninth_tid", req_dcache_o.tid, 8);
    tick(); req_valid_i = '0;

    // Bad sid, sticky error, reset during AMO_WAIT.
    do_reset();
    rsp(1, 3, 0); #1;
    chk("t6_bad_sid_rsp", rsp_valid_o, 0);
    tick(); rsp(0, 0, 0); #1;
    chk("t6_err_set", sid_err_o, 1);
    tick(); tick(); #1;
    chk("t6_err_sticky", sid_err_o, 1);
    set_req(2, 1, HPDCACHE_REQ_AMO_SWAP, 4); dcache_ready_i = 1'b1; #1;
    chk("t6_amo_direct", core_req_valid_o, 1);
    tick(); set_req(2, 0, HPDCACHE_REQ_AMO_SWAP, 4); #1;
    chk("t6_wait_busy", busy_o, 1);
    tick();
    do_reset(); #1;
    chk("t6_post_rst_busy", busy_o, 0);
    chk("t6_post_rst_err", sid_err_o, 0);
    chk("t6_post_rst_valid", core_req_valid_o, 0);
    rsp(1, 2, 4); #1;
    chk("t6_stale_rsp", rsp_valid_o, 0);
    tick(); rsp(0, 0, 0); #1;
    chk("t6_stale_err", sid_err_o, 1);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
- Shares the single HPDC core request port between NUM_REQ requesters: 0 = load/store unit, 1 = page-table walker, 2 = vector memory unit.
- Arbitrates round-robin and holds each request stable until the cache accepts it.
- Tracks outstanding transactions per requester, serialises AMOs and routes responses back by sid.
- Sits between the requesters' dcache interfaces and the HPDC.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- TID_W, 7, width of the transaction id; one pending bit per tid per requester.
- MAX_OUTST, 8, maximum outstanding requests per requester.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_i  in  NUM_REQ x hpdcache_req_t  per-requester request
- req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- core_req_valid_o  out  1  request valid to HPDC
- req_dcache_o  out  hpdcache_req_t  request to HPDC; sid overwritten with grantee index
- dcache_ready_i  in  1  HPDC accepts request
- dcache_valid_i  in  1  HPDC response valid
- rsp_dcache_i  in  hpdcache_rsp_t  HPDC response
- rsp_valid_o  out  NUM_REQ  routed response valid (one-hot or zero)
- rsp_o  out  hpdcache_rsp_t  response, broadcast to all requesters
- sid_err_o  out  1  sticky: response arrived with sid >= NUM_REQ, or with tid not pending
- busy_o  out  1  any transaction outstanding, or FSM not in ARB

Behaviour:
- Reset values: all outputs 0, FSM = ARB, rr_ptr = 0, all pending tables and counters cleared.
- Eligibility of requester i: req_valid_i[i], pending_i[req_i[i].tid] == 0, and outst_i < MAX_OUTST.
- Grant rule (ARB):
  - Pick the first eligible requester scanning from rr_ptr upward, with wrap.
  - Drive core_req_valid_o and req_dcache_o from the grantee in the same cycle; there is no added latency.
- Send: core_req_valid_o && dcache_ready_i.
  - req_ready_o[g] = 1.
  - Set pending_g[tid] and increment outst_g.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Not accepted in ARB: go to HOLD with the grantee latched.
- HOLD:
  - Keep the grant to the latched requester and re-arbitrate nothing.
  - Requesters must keep valid and the request stable; a dropped valid there is a requester bug (assertion).
  - Exit to ARB on send.
- AMO (op is any HPDCACHE_REQ_AMO_*):
  - Not grantable while total outstanding != 0: enter DRAIN with the AMO requester latched.
  - DRAIN blocks all other grants. When total reaches 0, issue the AMO (same hold rules).
  - Then go to AMO_WAIT: no grants until the response for that sid/tid returns, then back to ARB.
  - An AMO arriving with total already 0 goes straight from ARB to issue.
- Response (dcache_valid_i):
  - rsp_valid_o[sid] = 1 combinationally; rsp_o = rsp_dcache_i.
  - Clear pending_sid[tid] and decrement outst_sid.
  - If sid >= NUM_REQ or the tid is not pending: drop the response, set sid_err_o (held until reset) and leave the tables unchanged.
- Simultaneous send and response:
  - Same requester: the counter nets to 0 change.
  - Same requester and same tid: impossible, because a pending tid is ineligible. If both set and clear hit one bit anyway, set wins.
- Counter width is clog2(MAX_OUTST+1); it never wraps, guaranteed by the eligibility rule.
- Reset mid-operation clears everything. Responses to pre-reset requests then flag sid_err_o.

Decomposition:
- drac_pkg: arb_state_t {ARB, HOLD, DRAIN, AMO_WAIT}, the is_amo(op) function, and the DCACHE_NUM_REQ / DCACHE_TID_W constants.
- Sub-module dcache_txn_tracker, one instance per requester: pending bit table plus outstanding counter, with set/clear ports, eligible_o and empty_o.

Test Plan:
- R0 tid 5 load, R1 tid 5 load, both valid, ready=1 → R0 granted in cycle 0, R1 in cycle 1 (distinct sids). Responses sid 1 tid 5, then sid 0 tid 5 → rsp_valid_o = 010, then 001.
- All 3 valid continuously, ready=1, distinct tids → grant order 0,1,2,0,1,2.
- R1 valid, dcache_ready_i low for 4 cycles while R0 and R2 are also valid → req_dcache_o holds R1 for the whole stall; R1 is accepted in cycle 4; the next grant is R2.
- R0 has 2 loads outstanding, then R2 AMO_ADD → DRAIN until both responses return. The AMO then issues; no grant while in AMO_WAIT; its response returns the FSM to ARB.
- R0 issues 8 loads with no responses → the 9th is blocked. One response arrives in the same cycle as the 9th request → the 9th is granted the following cycle.
- Response with sid = 3 → no rsp_valid_o, sid_err_o = 1 and stays 1. Reset mid-AMO_WAIT → FSM = ARB and busy_o = 0 after reset.
